lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-wide data_mem port (mem_write, mem_read, addr, write_data, read_data) on behalf of the RV32I core.
- Accepts one LB/LH/LW/LBU/LHU/SB/SH/SW request at a time.
- Issues word-aligned memory accesses and performs read-modify-write for sub-word stores, because data_mem writes whole words only.
- Returns sign/zero-extended load data, or an error response for misaligned or unsupported accesses.

Parameters:
ADDR_W, 32, byte-address width on both core and memory sides
XLEN, 32, data width; only 32 is supported, elaboration error otherwise

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  block can accept a request; high only in IDLE
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-justified
resp_valid  out  1  one-cycle pulse, request complete
resp_err  out  1  qualifies resp_valid; misaligned or unsupported funct3
resp_rdata  out  XLEN  extended load data; 0 for stores and errors
mem_read  out  1  to data_mem
mem_write  out  1  to data_mem
mem_addr  out  ADDR_W  to data_mem addr, always {req_addr[31:2],2'b00}
mem_wdata  out  XLEN  to data_mem write_data
mem_rdata  in  XLEN  from data_mem read_data; valid the cycle after mem_read is sampled high

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0 except req_ready=1 after release. In-flight request dropped; mem_write deasserts immediately.
- Handshake: transfer when req_valid&&req_ready at a rising edge. funct3, addr, wdata and we are latched at that edge. Inputs are ignored outside IDLE.
- FSM states: IDLE, RD_REQ, RD_CAP, WR, DONE.
- IDLE, on accept:
  - error (misaligned or bad funct3) -> DONE with err.
  - load or SB/SH -> RD_REQ.
  - SW -> WR.
- RD_REQ: mem_read=1, mem_addr driven -> RD_CAP.
- RD_CAP: mem_read=1, mem_rdata captured into word buffer at end of cycle. Load -> DONE; store -> WR.
- WR: mem_write=1 for exactly one cycle, mem_wdata = merged word -> DONE.
- DONE: resp_valid=1 for one cycle -> IDLE. The next request may be accepted on the following edge.
- Latency from accept edge to resp_valid high:
  - load: 3 cycles
  - SW: 2 cycles
  - SB/SH: 4 cycles
  - error: 1 cycle
- Alignment:
  - H/HU/SH misaligned when addr[0]=1.
  - W/SW misaligned when addr[1:0]!=0.
  - funct3 011/110/111 is an error for loads.
  - funct3 other than 000/001/010 is an error for stores.
  - Errors never assert mem_read or mem_write.
- Byte lanes are little-endian: byte k occupies bits[8k+7:8k], k=addr[1:0]. Halfword lane is addr[1].
- Load extraction: B/H sign-extend bit 7/15; BU/HU zero-extend.
- Store merge: buffer word with the selected lane replaced by req_wdata[7:0] or [15:0]. Other lanes are unchanged.
- mem_wdata is 0 outside WR; mem_addr is held stable from RD_REQ through WR.
- resp_rdata is registered and valid only with resp_valid; otherwise 0.

Optional Feature:
- Macro LSU_PERF_CNT_EN.
- Defined: adds outputs load_cnt and store_cnt (32-bit each, reset 0).
  - Each increments by 1 in DONE for a non-error load or store respectively.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - enum lsu_state_e {IDLE, RD_REQ, RD_CAP, WR, DONE}
  - function is_misaligned(funct3, addr[1:0])
- One combinational sub-module, lsu_lane_align, holds extraction and merge (inputs word, addr[1:0], funct3, wdata; outputs ext_rdata, merged_wdata). The top keeps the FSM and registers.

Test Plan:
- Preload mem[0x04]=0x8899AABB; LB @0x05 -> resp_rdata=0xFFFFFFAA, resp_err=0, resp_valid 3 cycles after accept. LBU @0x05 -> 0x000000AA.
- LH @0x06 -> 0xFFFF8899; LHU @0x06 -> 0x00008899; LH @0x07 -> resp_err=1, resp_rdata=0, no mem_read pulse, 1-cycle latency.
- SB @0x06 wdata=0x00000012 -> RD_REQ/RD_CAP/WR sequence, single mem_write with mem_addr=0x04, mem_wdata=0x8812AABB; follow-up LW @0x04 -> 0x8812AABB.
- SW @0x10 wdata=0xCAFEBABE -> no mem_read, mem_write one cycle, 2-cycle latency; LW @0x10 -> 0xCAFEBABE. SW @0x12 -> resp_err=1, memory unchanged.
- Assert rst_n=0 mid-SH while in RD_CAP -> outputs 0 asynchronously, no mem_write ever issued, memory word unchanged; after release req_ready=1 and a new LW completes normally.
- With LSU_PERF_CNT_EN: 3 good loads, 2 good stores, 1 misaligned load -> load_cnt=3, store_cnt=2.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state encoding and access-legality helpers for lsu_mem_master.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_CAP, WR, DONE} lsu_state_e;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return (f3 == F3_H || f3 == F3_HU) ? a[0] : (f3 == F3_W) ? (a != 2'b00) : 1'b0;
    endfunction

    // Stores only know B/H/W; loads additionally accept BU/HU.
    function automatic logic is_bad_f3(input logic we, input logic [2:0] f3);
        return we ? (f3 > F3_W) : (f3 == 3'b011 || f3[2:1] == 2'b11);
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian byte/halfword extraction for loads and lane merge for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ext_rdata_o,
    output logic [31:0] merged_wdata_o
);
    logic [4:0]  bsh, hsh;
    logic [7:0]  b;
    logic [15:0] h;

    assign bsh = {addr_i, 3'b000};
    assign hsh = {addr_i[1], 4'b0000};
    assign b   = 8'(word_i >> bsh);
    assign h   = 16'(word_i >> hsh);

    assign ext_rdata_o = (funct3_i == F3_B)  ? {{24{b[7]}}, b} :
                         (funct3_i == F3_BU) ? {24'd0, b} :
                         (funct3_i == F3_H)  ? {{16{h[15]}}, h} :
                         (funct3_i == F3_HU) ? {16'd0, h} : word_i;

    assign merged_wdata_o = (funct3_i == F3_B) ? ((word_i & ~(32'h0000_00FF << bsh)) | ({24'd0, wdata_i[7:0]} << bsh)) :
                            (funct3_i == F3_H) ? ((word_i & ~(32'h0000_FFFF << hsh)) | ({16'd0, wdata_i[15:0]} << hsh)) :
                            wdata_i;
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding RV32I load/store initiator for a word-only data_mem, with RMW sub-word stores.
// Optional LSU_PERF_CNT_EN adds load_cnt_o/store_cnt_o completion counters.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              resp_valid_o,
    output logic              resp_err_o,
    output logic [XLEN-1:0]   resp_rdata_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic [XLEN-1:0]   mem_rdata_i
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]       load_cnt_o,
    output logic [31:0]       store_cnt_o
`endif
);
    if (XLEN != 32) begin : g_xlen_chk
        $error("lsu_mem_master supports XLEN=32 only");
    end

    lsu_state_e        state_q;
    logic              we_q, err_q, rvalid_q, rd_q, wr_q;
    logic [2:0]        f3_q;
    logic [1:0]        lo_q;
    logic [XLEN-1:0]   wdata_q, rdata_q, wd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       ext_rdata, merged_wdata;
    logic              acc_err;

    assign acc_err = is_misaligned(req_funct3_i, req_addr_i[1:0]) || is_bad_f3(req_we_i, req_funct3_i);

    // RD_CAP sees the read word directly on mem_rdata_i; the merge result is registered into the write buffer.
    lsu_lane_align u_align (
        .word_i         (mem_rdata_i),
        .addr_i         (lo_q),
        .funct3_i       (f3_q),
        .wdata_i        (wdata_q),
        .ext_rdata_o    (ext_rdata),
        .merged_wdata_o (merged_wdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= '0;
            lo_q     <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wd_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    we_q    <= req_we_i;
                    f3_q    <= req_funct3_i;
                    lo_q    <= req_addr_i[1:0];
                    wdata_q <= req_wdata_i;
                    if (acc_err) begin
                        err_q    <= 1'b1;
                        rvalid_q <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        addr_q <= {req_addr_i[ADDR_W-1:2], 2'b00};
                        if (req_we_i && req_funct3_i == F3_W) begin
                            wr_q    <= 1'b1;
                            wd_q    <= req_wdata_i;
                            state_q <= WR;
                        end else begin
                            rd_q    <= 1'b1;
                            state_q <= RD_REQ;
                        end
                    end
                end
                RD_REQ: state_q <= RD_CAP;
                RD_CAP: begin
                    rd_q <= 1'b0;
                    if (we_q) begin
                        wr_q    <= 1'b1;
                        wd_q    <= merged_wdata;
                        state_q <= WR;
                    end else begin
                        addr_q   <= '0;
                        rvalid_q <= 1'b1;
                        rdata_q  <= ext_rdata;
                        state_q  <= DONE;
                    end
                end
                WR: begin
                    wr_q     <= 1'b0;
                    wd_q     <= '0;
                    addr_q   <= '0;
                    rvalid_q <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                    err_q    <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = rvalid_q;
    assign resp_err_o   = err_q;
    assign resp_rdata_o = rdata_q;
    assign mem_read_o   = rd_q;
    assign mem_write_o  = wr_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wd_q;

`ifdef LSU_PERF_CNT_EN
    logic [31:0] load_cnt_q, store_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else if (state_q == DONE && !err_q) begin
            if (we_q) store_cnt_q <= store_cnt_q + 32'd1;
            else      load_cnt_q  <= load_cnt_q + 32'd1;
        end
    end

    assign load_cnt_o  = load_cnt_q;
    assign store_cnt_o = store_cnt_q;
`endif
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: table-driven directed bench for lsu_mem_master against a simple word-wide data_mem model.
module tb_lsu_mem_master;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [0:63];
    int          checks = 0, errors = 0, wrcnt = 0, exp_ld = 0, exp_st = 0;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] load_cnt, store_cnt;
`endif

    lsu_mem_master #(.ADDR_W(32), .XLEN(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_err_o(resp_err), .resp_rdata_o(resp_rdata),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
`ifdef LSU_PERF_CNT_EN
        , .load_cnt_o(load_cnt), .store_cnt_o(store_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_read) mem_rdata <= mem[mem_addr[7:2]];
        if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            wrcnt <= wrcnt + 1;
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] mwd;
    } vec_t;

    vec_t vt [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        int lat = 0, nrd = 0, nwr = 0;
        logic [31:0] wa = 0, wd = 0, rd = 0;
        logic er = 0;
        @(negedge clk);
        chk($sformatf("v%0d ready", idx), {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0; req_we = ~v.we; req_funct3 = 3'b111; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (mem_read) nrd++;
            if (mem_write) begin nwr++; wa = mem_addr; wd = mem_wdata; end
            if (resp_valid) begin lat = i; er = resp_err; rd = resp_rdata; end
        end
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d err", idx), {31'd0, er}, {31'd0, v.err});
        chk($sformatf("v%0d rdata", idx), rd, v.rdata);
        chk($sformatf("v%0d rd_cycles", idx), 32'(nrd), (v.lat == 3 || v.lat == 4) ? 32'd2 : 32'd0);
        chk($sformatf("v%0d wr_cycles", idx), 32'(nwr), (v.lat == 2 || v.lat == 4) ? 32'd1 : 32'd0);
        if (nwr == 1) begin
            chk($sformatf("v%0d mem_addr", idx), wa, v.addr & 32'hFFFF_FFFC);
            chk($sformatf("v%0d mem_wdata", idx), wd, v.mwd);
        end
        @(negedge clk);
        chk($sformatf("v%0d pulse", idx), {31'd0, resp_valid}, 32'd0);
        if (!v.err) begin
            if (v.we) exp_st++;
            else exp_ld++;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[1] = 32'h8899_AABB;
        mem_rdata = 32'd0;
        vt[0]  = '{0, 3'b000, 32'h05, 32'h0,        0, 32'hFFFF_FFAA, 3, 32'h0};
        vt[1]  = '{0, 3'b100, 32'h05, 32'h0,        0, 32'h0000_00AA, 3, 32'h0};
        vt[2]  = '{0, 3'b001, 32'h06, 32'h0,        0, 32'hFFFF_8899, 3, 32'h0};
        vt[3]  = '{0, 3'b101, 32'h06, 32'h0,        0, 32'h0000_8899, 3, 32'h0};
        vt[4]  = '{0, 3'b001, 32'h07, 32'h0,        1, 32'h0,         1, 32'h0};
        vt[5]  = '{1, 3'b000, 32'h06, 32'h12,       0, 32'h0,         4, 32'h8812_AABB};
        vt[6]  = '{0, 3'b010, 32'h04, 32'h0,        0, 32'h8812_AABB, 3, 32'h0};
        vt[7]  = '{1, 3'b010, 32'h10, 32'hCAFEBABE, 0, 32'h0,         2, 32'hCAFE_BABE};
        vt[8]  = '{0, 3'b010, 32'h10, 32'h0,        0, 32'hCAFE_BABE, 3, 32'h0};
        vt[9]  = '{1, 3'b010, 32'h12, 32'h12345678, 1, 32'h0,         1, 32'h0};
        vt[10] = '{0, 3'b010, 32'h10, 32'h0,        0, 32'hCAFE_BABE, 3, 32'h0};
        vt[11] = '{1, 3'b001, 32'h06, 32'hFFFF1234, 0, 32'h0,         4, 32'h1234_AABB};
        vt[12] = '{0, 3'b000, 32'h07, 32'h0,        0, 32'h0000_0012, 3, 32'h0};
        vt[13] = '{0, 3'b011, 32'h04, 32'h0,        1, 32'h0,         1, 32'h0};
        vt[14] = '{1, 3'b100, 32'h04, 32'h55,       1, 32'h0,         1, 32'h0};
        vt[15] = '{0, 3'b101, 32'h07, 32'h0,        1, 32'h0,         1, 32'h0};
        vt[16] = '{0, 3'b010, 32'h06, 32'h0,        1, 32'h0,         1, 32'h0};
        vt[17] = '{1, 3'b000, 32'h04, 32'hAB,       0, 32'h0,         4, 32'h1234_AAAB};
        vt[18] = '{0, 3'b000, 32'h04, 32'h0,        0, 32'hFFFF_FFAB, 3, 32'h0};
        vt[19] = '{1, 3'b001, 32'h04, 32'h7F00,     0, 32'h0,         4, 32'h1234_7F00};
        vt[20] = '{0, 3'b001, 32'h04, 32'h0,        0, 32'h0000_7F00, 3, 32'h0};
        vt[21] = '{0, 3'b100, 32'h05, 32'h0,        0, 32'h0000_007F, 3, 32'h0};
        vt[22] = '{0, 3'b001, 32'h06, 32'h0,        0, 32'h0000_1234, 3, 32'h0};

        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("rst req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 23; i++) run(vt[i], i);

`ifdef LSU_PERF_CNT_EN
        chk("load_cnt", load_cnt, 32'(exp_ld));
        chk("store_cnt", store_cnt, 32'(exp_st));
`endif

        // Abort an SH to 0x10 while it sits in RD_CAP.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h10; req_wdata = 32'h5555;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 chk("abort rd_cap mem_read", {31'd0, mem_read}, 32'd1);
        chk("abort rd_cap ready", {31'd0, req_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort mem_read", {31'd0, mem_read}, 32'd0);
        chk("abort mem_write", {31'd0, mem_write}, 32'd0);
        chk("abort mem_addr", mem_addr, 32'd0);
        chk("abort resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("abort ready", {31'd0, req_ready}, 32'd1);
        chk("abort mem word", mem[4], 32'hCAFE_BABE);
        exp_ld = 0; exp_st = 0;
        run(vt[8], 100);
        chk("abort no writes", 32'(wrcnt), 32'd5);
`ifdef LSU_PERF_CNT_EN
        chk("load_cnt after rst", load_cnt, 32'(exp_ld));
        chk("store_cnt after rst", store_cnt, 32'(exp_st));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
